// File: rtl/dmem_resp_pkg.sv
// ============================================================================
// dmem_resp_pkg : shared types, widths and address decode for dmem_responder
// Revision 1.0
// ============================================================================
`default_nettype none

package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // The region end is formed at 33 bits so a window ending at 2^32 does not wrap.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] limit;
    limit = {1'b0, base} + ({1'b0, depth} << 2);
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram_be.sv
// ============================================================================
// dmem_ram_be : word RAM with byte-enabled write and registered read on one enable
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_ram_be
  import dmem_resp_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Read returns the pre-write word; loads never write, so this only matters for stores.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : valid/ready data-memory slave with wait states and error flags
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        err_sticky
);

  localparam int       AW       = $clog2(DEPTH_WORDS);
  localparam logic     DIRECT   = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;
  logic              load_ok;
  logic [WORD_W-1:0] ram_rdata;

  logic              idle;
  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic              cur_err;
  logic [AW-1:0]     cur_idx;

  assign idle      = (state == IDLE);
  assign req_ready = idle && !reset;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access is decoded straight from the request inputs.
  assign cur_we    = idle ? req_we    : lat_we;
  assign cur_addr  = idle ? req_addr  : lat_addr;
  assign cur_wdata = idle ? req_wdata : lat_wdata;
  assign cur_be    = idle ? req_be    : lat_be;
  assign cur_err   = addr_err(cur_addr, BASE_ADDR, DEPTH_WORDS);
  assign cur_idx   = AW'((cur_addr - BASE_ADDR) >> 2);

  assign enter_resp = (idle && accept && DIRECT) || (state == WAIT && cnt == 4'd0);

  assign rsp_rdata = load_ok ? ram_rdata : '0;

  dmem_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (enter_resp),
    .we    (cur_we && !cur_err),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
      load_ok    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= CNT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_ok   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Response entry overrides the WAIT transition taken above on a zero-latency accept.
      if (enter_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err;
        load_ok   <= !cur_we && !cur_err;
        if (cur_err) err_sticky <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : two responder instances (2 and 0 wait states) against a byte model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int          LAT   [2] = '{2, 0};
  localparam int          DEPS  [2] = '{64, 16};
  localparam logic [31:0] BASES [2] = '{32'h0000_0000, 32'h0000_1000};

  logic        clk;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        err_sticky[2];

  // Reference model: byte contents plus which bytes have ever been written.
  logic [31:0] mem_m   [2][64];
  logic [3:0]  known_m [2][64];
  logic        sticky_m[2];
  time         last_acc[2];

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .err_sticky(err_sticky[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .err_sticky(err_sticky[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input int u, input logic [31:0] a);
    longint unsigned ua, lo, hi;
    ua = {32'h0, a};
    lo = {32'h0, BASES[u]};
    hi = lo + 64'(4 * DEPS[u]);
    return (a % 4 != 0) || (ua < lo) || (ua >= hi);
  endfunction

  // One complete transaction; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic do_txn(input int u, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, input bit gapchk,
                        output logic [31:0] got);
    bit          e;
    int          w, n;
    logic [31:0] mask, exp_rd;
    time         t;
    e = ref_err(u, a);
    w = e ? 0 : int'((a - BASES[u]) / 4);
    mask = '0;
    for (int b = 0; b < 4; b++) if (known_m[u][w][b]) mask[8*b +: 8] = 8'hFF;
    exp_rd = (we || e) ? 32'h0 : mem_m[u][w];
    if (we || e) mask = 32'hFFFF_FFFF;

    @(negedge clk);
    rsp_ready[u] = (hold == 0);
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = a; req_wdata[u] = wd; req_be[u] = be;
    n = 0;
    while (!req_ready[u] && n < 20) begin @(negedge clk); n++; end
    check($sformatf("u%0d req_ready", u), 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    t = $time;
    #1 req_valid[u] = 1'b0;
    if (gapchk) check($sformatf("u%0d accept_gap", u), 32'((t - last_acc[u]) / 10), 32'(LAT[u] + 2));
    last_acc[u] = t;

    // Counting the acceptance edge as the first, the response shows after LATENCY+1 edges.
    n = 0;
    while (!rsp_valid[u] && n < 40) begin @(posedge clk); #1; n++; end
    check($sformatf("u%0d latency a=%h", u, a), 32'(n), 32'(LAT[u]));
    check($sformatf("u%0d rsp_err a=%h", u, a), 32'(rsp_err[u]), 32'(e));
    check($sformatf("u%0d rdata a=%h", u, a), rsp_rdata[u] & mask, exp_rd & mask);
    if (e) sticky_m[u] = 1'b1;
    check($sformatf("u%0d sticky", u), 32'(err_sticky[u]), 32'(sticky_m[u]));
    got = rsp_rdata[u];
    if (we && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_m[u][w][8*b +: 8] = wd[8*b +: 8];
          known_m[u][w][b] = 1'b1;
        end
      end
    end

    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check($sformatf("u%0d hold_valid", u), 32'(rsp_valid[u]), 32'd1);
        check($sformatf("u%0d hold_rdata", u), rsp_rdata[u] & mask, exp_rd & mask);
        check($sformatf("u%0d hold_err", u), 32'(rsp_err[u]), 32'(e));
        check($sformatf("u%0d hold_req_ready", u), 32'(req_ready[u]), 32'd0);
      end
      @(negedge clk);
      rsp_ready[u] = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("u%0d post_valid", u), 32'(rsp_valid[u]), 32'd0);
    check($sformatf("u%0d post_err", u), 32'(rsp_err[u]), 32'd0);
    check($sformatf("u%0d post_rdata", u), rsp_rdata[u], 32'd0);
    check($sformatf("u%0d post_req_ready", u), 32'(req_ready[u]), 32'd1);
  endtask

  // Store, then assert reset at the falling edge right after acceptance.
  task automatic reset_mid(input int u, input logic [31:0] a, input logic [31:0] wd);
    int w, n;
    w = int'((a - BASES[u]) / 4);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = a; req_wdata[u] = wd; req_be[u] = 4'hF;
    n = 0;
    while (!req_ready[u] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    @(negedge clk);
    reset[u] = 1'b1;
    #1;
    check($sformatf("u%0d rst_req_ready", u), 32'(req_ready[u]), 32'd0);
    check($sformatf("u%0d rst_rsp_valid", u), 32'(rsp_valid[u]), 32'd0);
    check($sformatf("u%0d rst_rsp_err", u), 32'(rsp_err[u]), 32'd0);
    check($sformatf("u%0d rst_rdata", u), rsp_rdata[u], 32'd0);
    check($sformatf("u%0d rst_sticky", u), 32'(err_sticky[u]), 32'd0);
    // Zero wait states means the write already happened on the acceptance edge.
    if (LAT[u] == 0) begin
      mem_m[u][w] = wd;
      known_m[u][w] = 4'hF;
    end
    sticky_m[u] = 1'b0;
    @(negedge clk);
    reset[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    #1 check($sformatf("u%0d rel_req_ready", u), 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got, a;
    int r;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0; req_be[u] = '0; rsp_ready[u] = 1'b1; sticky_m[u] = 1'b0;
      last_acc[u] = 0;
      for (int i = 0; i < 64; i++) begin mem_m[u][i] = '0; known_m[u][i] = '0; end
    end
    #2;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d init_req_ready", u), 32'(req_ready[u]), 32'd0);
      check($sformatf("u%0d init_rsp_valid", u), 32'(rsp_valid[u]), 32'd0);
      check($sformatf("u%0d init_rsp_err", u), 32'(rsp_err[u]), 32'd0);
      check($sformatf("u%0d init_rdata", u), rsp_rdata[u], 32'd0);
      check($sformatf("u%0d init_sticky", u), 32'(err_sticky[u]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset[0] = 1'b0; reset[1] = 1'b0;
    #1;
    for (int u = 0; u < 2; u++)
      check($sformatf("u%0d first_req_ready", u), 32'(req_ready[u]), 32'd1);

    // Directed sequence on the two-wait-state unit.
    do_txn(0, 1, 32'h64, 32'h0000_0400, 4'hF, 0, 0, got);
    do_txn(0, 0, 32'h64, 32'h0, 4'h0, 0, 0, got);
    check("raw load_0x64", got, 32'h0000_0400);
    do_txn(0, 1, 32'h10, 32'h1122_3344, 4'hF, 0, 0, got);
    do_txn(0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0, 0, got);
    do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0, got);
    check("raw merge_0x10", got, 32'h11BB_33DD);
    do_txn(0, 1, 32'h66, 32'hFFFF_FFFF, 4'hF, 0, 0, got);
    do_txn(0, 0, 32'h64, 32'h0, 4'h0, 0, 0, got);
    check("raw no_corrupt_0x64", got, 32'h0000_0400);
    do_txn(0, 0, 32'h100, 32'h0, 4'h0, 0, 0, got);
    do_txn(0, 0, 32'hFC, 32'h0, 4'h0, 0, 0, got);
    do_txn(0, 1, 32'h64, 32'h5555_5555, 4'h0, 0, 0, got);
    do_txn(0, 0, 32'h64, 32'h0, 4'h0, 3, 0, got);
    check("raw be0_noop_0x64", got, 32'h0000_0400);
    do_txn(0, 1, 32'h20, 32'h1234_5678, 4'hF, 0, 0, got);
    reset_mid(0, 32'h20, 32'hDEAD_BEEF);
    do_txn(0, 0, 32'h20, 32'h0, 4'h0, 0, 0, got);
    check("raw uncommitted_0x20", 32'(got == 32'hDEAD_BEEF), 32'd0);

    // Zero-wait-state unit with a non-zero base.
    do_txn(1, 1, 32'h1000, 32'hCAFE_F00D, 4'hF, 0, 0, got);
    do_txn(1, 0, 32'h1000, 32'h0, 4'h0, 2, 0, got);
    check("raw u1_load_0x1000", got, 32'hCAFE_F00D);
    do_txn(1, 0, 32'h1040, 32'h0, 4'h0, 0, 0, got);
    do_txn(1, 0, 32'h0FFC, 32'h0, 4'h0, 0, 0, got);
    reset_mid(1, 32'h1008, 32'h5A5A_5A5A);
    do_txn(1, 0, 32'h1008, 32'h0, 4'h0, 0, 0, got);
    check("raw u1_committed_0x1008", got, 32'h5A5A_5A5A);

    // Back-to-back bursts with rsp_ready high; acceptances must be LATENCY+2 apart.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 6; i++)
        do_txn(u, i[0], BASES[u] + 32'(4 * i), $urandom, 4'hF, 0, (i != 0), got);

    // Randomized traffic mixing in-range, misaligned and out-of-range accesses.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 40; i++) begin
        r = int'($urandom_range(0, 9));
        if (r <= 6)      a = BASES[u] + 32'(4 * $urandom_range(0, DEPS[u] - 1));
        else if (r == 7) a = BASES[u] + 32'(4 * $urandom_range(0, DEPS[u] - 1)) + 32'($urandom_range(1, 3));
        else if (r == 8) a = BASES[u] + 32'(4 * DEPS[u]) + 32'(4 * $urandom_range(0, 15));
        else             a = BASES[u] - 32'd4;
        do_txn(u, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0, 0, got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
